frame_src_ctrl: RTL and testbench
=================================

FRAME_SRC_CTRL -- requirements
Module: frame_src_ctrl

Interface
REQ-001 Parameters SHALL be:
  - DATA_WIDTH, default 8, bits per colour channel.
  - IMG_WIDTH, default 80, pixels per line.
  - IMG_HEIGHT, default 120, lines per frame.
  - TOTAL_PIXELS, default IMG_WIDTH*IMG_HEIGHT, pixels per frame.
  - ADDR_WIDTH, default $clog2(TOTAL_PIXELS), frame-buffer address width.
  - TIMEOUT_CYCLES, default 1_000_000, maximum idle gap between UART pixels.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock.
  - reset  in  1  asynchronous, active-high.
  - start  in  1  one-cycle request to capture one frame.
  - abort  in  1  cancel the capture in progress.
  - mode_req  in  1  source select (1 camera, 0 UART), sampled on an accepted start.
  - cam_vsync  in  1  camera frame-start level.
  - cam_pixel_valid  in  1  camera pixel strobe.
  - cam_rgb  in  3*DATA_WIDTH  camera pixel.
  - uart_pixel_done  in  1  UART assembled-pixel strobe.
  - uart_rgb  in  3*DATA_WIDTH  UART pixel.
  - cam_mode  out  1  latched source, drives the UART receive path.
  - fb_we  out  1  frame-buffer write enable.
  - fb_addr  out  ADDR_WIDTH  write address.
  - fb_wdata  out  3*DATA_WIDTH  write data.
  - busy  out  1  capture in progress.
  - frame_ready  out  1  one-cycle pulse, frame complete.
  - err_timeout  out  1  one-cycle pulse, UART stall.
  - err_sync  out  1  one-cycle pulse, camera resync.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, CAM_WAIT_VSYNC, CAM_RX, UART_RX, DONE.
REQ-004 IDLE: start=1 SHALL latch mode_req into cam_mode and clear the pixel counter; next state is CAM_WAIT_VSYNC if mode_req=1, otherwise UART_RX.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 cam_mode SHALL change only on an accepted start and SHALL hold its value through DONE and the following IDLE.
REQ-007 CAM_WAIT_VSYNC SHALL advance to CAM_RX on the first cycle cam_vsync=1; cam_pixel_valid SHALL be ignored until then.
REQ-008 In CAM_RX, cam_vsync rising SHALL reset the pixel counter to 0 and pulse err_sync; the state SHALL remain CAM_RX.
REQ-009 In CAM_RX/UART_RX, a strobe from the selected source SHALL produce fb_we=1 on the next cycle, with fb_addr = counter value and fb_wdata = that pixel; the counter SHALL then increment (latency 1 cycle).
REQ-010 Strobes from the non-selected source SHALL never cause a write.
REQ-011 A write at address TOTAL_PIXELS-1 SHALL move the FSM to DONE; DONE SHALL last 1 cycle with frame_ready=1, then return to IDLE.
REQ-012 The counter SHALL never exceed TOTAL_PIXELS-1 and SHALL never wrap within a frame.
REQ-013 UART_RX SHALL count idle cycles since the last uart_pixel_done (counter cleared on each strobe).
REQ-014 When the idle count reaches TIMEOUT_CYCLES, the block SHALL pulse err_timeout, return to IDLE, and issue no frame_ready.
REQ-015 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next cycle with no frame_ready.
REQ-016 abort SHALL have priority over a same-cycle pixel strobe, timeout, or last-pixel write; no fb_we SHALL follow an abort cycle.
REQ-017 busy SHALL be 1 in CAM_WAIT_VSYNC, CAM_RX, UART_RX and DONE, and 0 in IDLE.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 reset=1 SHALL asynchronously force IDLE and set cam_mode=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, frame_ready=0, err_timeout=0, err_sync=0, and both counters to 0.
REQ-020 Reset mid-frame SHALL discard the partial frame; the first start after release SHALL begin at address 0.

Verification
REQ-021 UART frame: start with mode_req=0, then 9600 uart_pixel_done strobes -> 9600 writes, addr 0..9599, frame_ready exactly 1 cycle after the last write, cam_mode=0.
REQ-022 Camera frame: start with mode_req=1, cam_pixel_valid before vsync (ignored), then vsync and 9600 pixels -> first write at addr 0, frame_ready asserted, cam_mode=1.
REQ-023 Source isolation: in UART mode, drive cam_pixel_valid every cycle -> no fb_we from camera traffic; only uart_rgb data is written.
REQ-024 Timeout: with TIMEOUT_CYCLES=100, send 10 UART pixels then stall -> err_timeout pulses 100 cycles after the 10th strobe, busy=0, no frame_ready.
REQ-025 Abort/priority: assert abort on the same cycle as the 9600th strobe -> no write at 9599, no frame_ready, IDLE next cycle; a start issued while busy is ignored.
REQ-026 Resync and reset: vsync at pixel 500 -> err_sync pulse, next write at addr 0; asynchronous reset at pixel 300 -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/frame_src_ctrl_if.sv
// Control, camera, UART and frame-buffer signals of the frame source controller.
// master drives the requests and pixel sources; slave is the controller.
interface frame_src_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
);
    logic                    start;
    logic                    abort;
    logic                    mode_req;
    logic                    cam_vsync;
    logic                    cam_pixel_valid;
    logic [3*DATA_WIDTH-1:0] cam_rgb;
    logic                    uart_pixel_done;
    logic [3*DATA_WIDTH-1:0] uart_rgb;
    logic                    cam_mode;
    logic                    fb_we;
    logic [ADDR_WIDTH-1:0]   fb_addr;
    logic [3*DATA_WIDTH-1:0] fb_wdata;
    logic                    busy;
    logic                    frame_ready;
    logic                    err_timeout;
    logic                    err_sync;

    modport master (
        output start, abort, mode_req, cam_vsync, cam_pixel_valid, cam_rgb,
               uart_pixel_done, uart_rgb,
        input  cam_mode, fb_we, fb_addr, fb_wdata, busy, frame_ready,
               err_timeout, err_sync
    );

    modport slave (
        input  start, abort, mode_req, cam_vsync, cam_pixel_valid, cam_rgb,
               uart_pixel_done, uart_rgb,
        output cam_mode, fb_we, fb_addr, fb_wdata, busy, frame_ready,
               err_timeout, err_sync
    );
endinterface

// File: rtl/frame_src_ctrl.sv
// Captures one frame from either the camera or the UART pixel stream into a
// frame buffer, with abort, UART stall timeout and camera resync handling.
module frame_src_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int IMG_WIDTH      = 80,
    parameter int IMG_HEIGHT     = 120,
    parameter int TOTAL_PIXELS   = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    frame_src_ctrl_if.slave bus
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PIX_W  = 3 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, CAM_WAIT_VSYNC, CAM_RX, UART_RX, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] pix_cnt, pix_cnt_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic              vsync_q, vsync_rise;
    logic              cam_mode_q, cam_mode_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [PIX_W-1:0]  wdata_q, wdata_nxt;
    logic              busy_q, busy_nxt;
    logic              ready_q, ready_nxt;
    logic              tmo_q, tmo_nxt;
    logic              sync_q, sync_nxt;
    logic              take;
    logic [PIX_W-1:0]  pix;
    logic              last;

    assign vsync_rise = bus.cam_vsync & ~vsync_q;
    assign last       = (pix_cnt == ADDR_WIDTH'(TOTAL_PIXELS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pix_cnt_nxt  = pix_cnt;
        idle_cnt_nxt = idle_cnt;
        cam_mode_nxt = cam_mode_q;
        we_nxt       = 1'b0;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        ready_nxt    = 1'b0;
        tmo_nxt      = 1'b0;
        sync_nxt     = 1'b0;
        take         = 1'b0;
        pix          = '0;

        case (state)
            IDLE: if (bus.start) begin
                cam_mode_nxt = bus.mode_req;
                pix_cnt_nxt  = '0;
                idle_cnt_nxt = '0;
                state_nxt    = bus.mode_req ? CAM_WAIT_VSYNC : UART_RX;
            end
            CAM_WAIT_VSYNC: if (bus.cam_vsync) state_nxt = CAM_RX;
            CAM_RX: begin
                // A fresh vsync restarts the frame; any pixel on that cycle is dropped.
                if (vsync_rise) begin
                    pix_cnt_nxt = '0;
                    sync_nxt    = 1'b1;
                end else if (bus.cam_pixel_valid) begin
                    take = 1'b1;
                    pix  = bus.cam_rgb;
                end
            end
            UART_RX: begin
                if (bus.uart_pixel_done) begin
                    take         = 1'b1;
                    pix          = bus.uart_rgb;
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            DONE: begin
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (take) begin
            we_nxt    = 1'b1;
            addr_nxt  = pix_cnt;
            wdata_nxt = pix;
            if (last) state_nxt = DONE;
            else      pix_cnt_nxt = pix_cnt + ADDR_WIDTH'(1);
        end

        // Abort overrides everything else decided this cycle.
        if (bus.abort && state != IDLE) begin
            state_nxt   = IDLE;
            pix_cnt_nxt = pix_cnt;
            we_nxt      = 1'b0;
            addr_nxt    = addr_q;
            wdata_nxt   = wdata_q;
            ready_nxt   = 1'b0;
            tmo_nxt     = 1'b0;
            sync_nxt    = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt    <= '0;
            idle_cnt   <= '0;
            vsync_q    <= 1'b0;
            cam_mode_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            tmo_q      <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            pix_cnt    <= pix_cnt_nxt;
            idle_cnt   <= idle_cnt_nxt;
            vsync_q    <= bus.cam_vsync;
            cam_mode_q <= cam_mode_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            busy_q     <= busy_nxt;
            ready_q    <= ready_nxt;
            tmo_q      <= tmo_nxt;
            sync_q     <= sync_nxt;
        end
    end

    assign bus.cam_mode    = cam_mode_q;
    assign bus.fb_we       = we_q;
    assign bus.fb_addr     = addr_q;
    assign bus.fb_wdata    = wdata_q;
    assign bus.busy        = busy_q;
    assign bus.frame_ready = ready_q;
    assign bus.err_timeout = tmo_q;
    assign bus.err_sync    = sync_q;
endmodule

// File: tb/tb_frame_src_ctrl.sv
// Directed bench for frame_src_ctrl: a short vector table plus full-frame,
// timeout, abort, resync and mid-frame reset sequences.
module tb_frame_src_ctrl;
    localparam int NPIX = 9600;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    frame_src_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) bus ();

    frame_src_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        st, ab, md, vs, cv, ud;
        logic [23:0] c_rgb, u_rgb;
        logic        we;
        logic [13:0] addr;
        logic [23:0] data;
        logic        busy, rdy, cm, sync, tmo;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t v(input logic st, ab, md, vs, cv, ud,
                               input logic [23:0] c_rgb, u_rgb,
                               input logic we, input logic [13:0] addr,
                               input logic [23:0] data,
                               input logic busy, rdy, cm, sync, tmo);
        vec_t r;
        r.st = st; r.ab = ab; r.md = md; r.vs = vs; r.cv = cv; r.ud = ud;
        r.c_rgb = c_rgb; r.u_rgb = u_rgb;
        r.we = we; r.addr = addr; r.data = data;
        r.busy = busy; r.rdy = rdy; r.cm = cm; r.sync = sync; r.tmo = tmo;
        return r;
    endfunction

    function automatic logic [43:0] obs();
        return {bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.busy, bus.frame_ready,
                bus.cam_mode, bus.err_sync, bus.err_timeout};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.abort = 0; bus.mode_req = 0; bus.cam_vsync = 0;
        bus.cam_pixel_valid = 0; bus.cam_rgb = '0;
        bus.uart_pixel_done = 0; bus.uart_rgb = '0;
    endtask

    initial begin
        logic [23:0] pat;
        int first_tmo, tmo_cnt, rdy_seen, busy_at_tmo;

        //             st ab md vs cv ud c_rgb        u_rgb        we ad  data        bs rd cm sy to
        tbl[0]  = v(0, 0, 0, 0, 0, 0, 24'h0,      24'h0,       0, 0, 24'h0,      0, 0, 0, 0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0, 0, 24'h0,      24'h0,       0, 0, 24'h0,      1, 0, 0, 0, 0);
        tbl[2]  = v(0, 0, 0, 0, 1, 1, 24'hC00001, 24'h111111,  1, 0, 24'h111111, 1, 0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 1, 0, 24'hC00002, 24'h0,       0, 0, 24'h111111, 1, 0, 0, 0, 0);
        tbl[4]  = v(0, 0, 0, 0, 0, 1, 24'h0,      24'h222222,  1, 1, 24'h222222, 1, 0, 0, 0, 0);
        tbl[5]  = v(1, 0, 1, 0, 0, 1, 24'h0,      24'h333333,  1, 2, 24'h333333, 1, 0, 0, 0, 0);
        tbl[6]  = v(0, 1, 0, 0, 0, 1, 24'h0,      24'h444444,  0, 2, 24'h333333, 0, 0, 0, 0, 0);
        tbl[7]  = v(0, 0, 0, 0, 0, 1, 24'h0,      24'h555555,  0, 2, 24'h333333, 0, 0, 0, 0, 0);
        tbl[8]  = v(1, 0, 1, 0, 0, 0, 24'h0,      24'h0,       0, 2, 24'h333333, 1, 0, 1, 0, 0);
        tbl[9]  = v(0, 0, 0, 0, 1, 0, 24'hC00009, 24'h0,       0, 2, 24'h333333, 1, 0, 1, 0, 0);
        tbl[10] = v(0, 0, 0, 1, 1, 0, 24'hC0000A, 24'h0,       0, 2, 24'h333333, 1, 0, 1, 0, 0);
        tbl[11] = v(0, 0, 0, 1, 1, 0, 24'hC0000B, 24'h0,       1, 0, 24'hC0000B, 1, 0, 1, 0, 0);
        tbl[12] = v(0, 0, 0, 1, 0, 1, 24'h0,      24'h666666,  0, 0, 24'hC0000B, 1, 0, 1, 0, 0);
        tbl[13] = v(0, 0, 0, 0, 1, 0, 24'hC0000D, 24'h0,       1, 1, 24'hC0000D, 1, 0, 1, 0, 0);
        tbl[14] = v(0, 0, 0, 1, 1, 0, 24'hC0000E, 24'h0,       0, 1, 24'hC0000D, 1, 0, 1, 1, 0);
        tbl[15] = v(0, 0, 0, 1, 1, 0, 24'hC0000F, 24'h0,       1, 0, 24'hC0000F, 1, 0, 1, 0, 0);
        tbl[16] = v(0, 1, 0, 1, 0, 0, 24'h0,      24'h0,       0, 0, 24'hC0000F, 0, 0, 1, 0, 0);

        clear_inputs();
        reset = 1'b1;
        repeat (3) step();
        chk("reset_state", 0, 64'(obs()), 64'd0);
        reset = 1'b0;

        for (int r = 0; r < 17; r++) begin
            bus.start = tbl[r].st; bus.abort = tbl[r].ab; bus.mode_req = tbl[r].md;
            bus.cam_vsync = tbl[r].vs; bus.cam_pixel_valid = tbl[r].cv;
            bus.cam_rgb = tbl[r].c_rgb; bus.uart_pixel_done = tbl[r].ud;
            bus.uart_rgb = tbl[r].u_rgb;
            step();
            chk("vec", r, 64'(obs()),
                64'({tbl[r].we, tbl[r].addr, tbl[r].data, tbl[r].busy, tbl[r].rdy,
                     tbl[r].cm, tbl[r].sync, tbl[r].tmo}));
        end
        clear_inputs();

        // Full UART frame with camera strobing every cycle alongside.
        bus.start = 1; bus.mode_req = 0; bus.cam_pixel_valid = 1; bus.cam_rgb = 24'hFFFFFF;
        step();
        chk("uart_start", 0, 64'({bus.busy, bus.cam_mode, bus.fb_we}), 64'b100);
        bus.start = 0;
        for (int i = 0; i < NPIX; i++) begin
            pat = {8'hA5, 16'(i)};
            bus.uart_pixel_done = 1; bus.uart_rgb = pat;
            step();
            chk("uart_px", i, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.frame_ready}),
                64'({1'b1, 14'(i), pat, 1'b0}));
        end
        bus.uart_pixel_done = 0; bus.cam_pixel_valid = 0;
        step();
        chk("uart_ready", 0, 64'({bus.frame_ready, bus.busy, bus.fb_we, bus.cam_mode}), 64'b1000);
        step();
        chk("uart_ready_pulse", 0, 64'(bus.frame_ready), 64'd0);

        // Camera frame: pixels before vsync are ignored.
        bus.start = 1; bus.mode_req = 1;
        step();
        chk("cam_start", 0, 64'({bus.busy, bus.cam_mode}), 64'b11);
        bus.start = 0; bus.mode_req = 0;
        for (int i = 0; i < 3; i++) begin
            bus.cam_pixel_valid = 1; bus.cam_rgb = 24'hBAD000 | 24'(i);
            step();
            chk("cam_prevsync", i, 64'({bus.fb_we, bus.busy}), 64'b01);
        end
        bus.cam_pixel_valid = 0; bus.cam_vsync = 1;
        step();
        chk("cam_vsync", 0, 64'({bus.fb_we, bus.busy, bus.err_sync}), 64'b010);
        for (int i = 0; i < NPIX; i++) begin
            pat = {8'h3C, 16'(i)};
            bus.cam_pixel_valid = 1; bus.cam_rgb = pat;
            step();
            chk("cam_px", i, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.frame_ready}),
                64'({1'b1, 14'(i), pat, 1'b0}));
        end
        bus.cam_pixel_valid = 0;
        step();
        chk("cam_ready", 0, 64'({bus.frame_ready, bus.busy, bus.cam_mode}), 64'b101);
        bus.cam_vsync = 0;
        step();

        // UART stall: ten pixels then silence.
        bus.start = 1; bus.mode_req = 0;
        step();
        bus.start = 0;
        for (int i = 0; i < 10; i++) begin
            pat = {8'h55, 16'(i)};
            bus.uart_pixel_done = 1; bus.uart_rgb = pat;
            step();
            chk("tmo_px", i, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata}),
                64'({1'b1, 14'(i), pat}));
        end
        bus.uart_pixel_done = 0;
        first_tmo = 0; tmo_cnt = 0; rdy_seen = 0; busy_at_tmo = 1;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (bus.err_timeout) begin
                tmo_cnt++;
                if (first_tmo == 0) begin
                    first_tmo   = k;
                    busy_at_tmo = bus.busy;
                end
            end
            if (bus.frame_ready) rdy_seen = 1;
        end
        chk("tmo_delay", 0, 64'(first_tmo), 64'd100);
        chk("tmo_width", 0, 64'(tmo_cnt), 64'd1);
        chk("tmo_busy", 0, 64'(busy_at_tmo), 64'd0);
        chk("tmo_no_ready", 0, 64'(rdy_seen), 64'd0);

        // Abort on the last strobe; a start mid-frame must be ignored.
        bus.start = 1; bus.mode_req = 0;
        step();
        for (int i = 0; i < NPIX - 1; i++) begin
            pat = {8'h77, 16'(i)};
            bus.start = (i == 100); bus.mode_req = (i == 100);
            bus.uart_pixel_done = 1; bus.uart_rgb = pat;
            step();
            chk("abort_px", i, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata}),
                64'({1'b1, 14'(i), pat}));
        end
        chk("busy_start_ignored", 0, 64'(bus.cam_mode), 64'd0);
        bus.start = 0; bus.mode_req = 0;
        bus.abort = 1; bus.uart_rgb = 24'hDEAD00;
        step();
        chk("abort_last", 0, 64'({bus.fb_we, bus.busy, bus.frame_ready}), 64'b000);
        bus.abort = 0; bus.uart_pixel_done = 0;
        step();
        chk("abort_after", 0, 64'({bus.fb_we, bus.busy, bus.frame_ready}), 64'b000);

        // Camera resync at pixel 500, then reset mid-frame at pixel 300.
        bus.start = 1; bus.mode_req = 1;
        step();
        bus.start = 0; bus.mode_req = 0; bus.cam_vsync = 1;
        step();
        for (int i = 0; i < 500; i++) begin
            pat = {8'h9E, 16'(i)};
            bus.cam_pixel_valid = 1; bus.cam_rgb = pat;
            step();
            chk("sync_px", i, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata}),
                64'({1'b1, 14'(i), pat}));
        end
        bus.cam_pixel_valid = 0; bus.cam_vsync = 0;
        step();
        bus.cam_vsync = 1;
        step();
        chk("err_sync", 0, 64'({bus.err_sync, bus.fb_we, bus.busy}), 64'b101);
        for (int i = 0; i < 300; i++) begin
            pat = {8'h4B, 16'(i)};
            bus.cam_pixel_valid = 1; bus.cam_rgb = pat;
            step();
            chk("resync_px", i, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.err_sync}),
                64'({1'b1, 14'(i), pat, 1'b0}));
        end
        reset = 1'b1;
        #1;
        chk("async_reset", 0, 64'(obs()), 64'd0);
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        step();
        bus.start = 1; bus.mode_req = 0;
        step();
        bus.start = 0;
        bus.uart_pixel_done = 1; bus.uart_rgb = 24'h123456;
        step();
        chk("post_reset_px", 0, 64'({bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.cam_mode}),
            64'({1'b1, 14'd0, 24'h123456, 1'b0}));
        bus.uart_pixel_done = 0; bus.abort = 1;
        step();
        bus.abort = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
